pc_redirect_ctrl: RTL and testbench

- Owns the architectural fetch PC and sequences PC updates from the execute-stage branch unit.
- Advances PC by 4 on each accepted fetch. Uses static not-taken prediction.
- On a taken branch/jump (branch unit's pc_next differs from ex_pc+4): loads the target, flushes the wrong-path front-end for FLUSH_CYCLES cycles, then resumes fetch.
- Traps misaligned targets to a fixed vector.

---
 rtl/pc_redirect_ctrl_pkg.sv | 13 +
 rtl/pc_redirect_ctrl_flush_timer.sv | 27 ++
 rtl/pc_redirect_ctrl.sv | 111 +++++++++++
 tb/tb_pc_redirect_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/pc_redirect_ctrl_pkg.sv
// rtl/pc_redirect_ctrl_pkg.sv - shared types and constants for the fetch PC redirect controller
package pc_redirect_ctrl_pkg;

    localparam int XLEN        = 32;
    localparam int INSN_BYTES  = 4;
    localparam int FLUSH_CNT_W = 4;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

endpackage

// File: rtl/pc_redirect_ctrl_flush_timer.sv
// rtl/pc_redirect_ctrl_flush_timer.sv - loadable down-counter that times the front-end flush window
module pc_redirect_ctrl_flush_timer
    import pc_redirect_ctrl_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load,
    input  logic [FLUSH_CNT_W-1:0] load_val,
    input  logic                   dec,
    output logic                   zero
);

    logic [FLUSH_CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/pc_redirect_ctrl.sv
// rtl/pc_redirect_ctrl.sv - owns the fetch PC; applies execute-stage redirects with a timed flush
module pc_redirect_ctrl
    import pc_redirect_ctrl_pkg::*;
#(
    parameter int                  X_LENGTH     = XLEN,
    parameter logic [X_LENGTH-1:0] RESET_PC     = '0,
    parameter logic [X_LENGTH-1:0] TRAP_VECTOR  = X_LENGTH'(32'h0000_0100),
    parameter int                  FLUSH_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stall,
    output logic                fetch_valid,
    input  logic                fetch_ready,
    output logic [X_LENGTH-1:0] fetch_pc,
    input  logic                ex_valid,
    input  logic                ex_branch,
    input  logic [X_LENGTH-1:0] ex_pc,
    input  logic [X_LENGTH-1:0] ex_pc_next,
    output logic                flush,
    output logic                redirect,
    output logic                exc_misaligned,
    output logic [X_LENGTH-1:0] exc_pc,
    output logic [31:0]         taken_count
);

    localparam logic [X_LENGTH-1:0]    PC_STEP    = X_LENGTH'(INSN_BYTES);
    localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

    state_t              state_q, state_d;
    logic [X_LENGTH-1:0] fetch_pc_q, fetch_pc_d;
    logic                flush_q, redirect_q, exc_q;
    logic [X_LENGTH-1:0] exc_pc_q;
    logic [31:0]         taken_count_q;

    logic take, misaligned, timer_load, timer_dec, timer_zero;

    assign fetch_valid = (state_q == RUN) && !stall;

    // Static not-taken: only a target other than the sequential PC is a redirect.
    assign take       = (state_q == RUN) && ex_valid && ex_branch &&
                        (ex_pc_next != (ex_pc + PC_STEP));
    assign misaligned = (ex_pc_next[1:0] != 2'b00);

    pc_redirect_ctrl_flush_timer u_flush_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (timer_load),
        .load_val (FLUSH_LOAD),
        .dec      (timer_dec),
        .zero     (timer_zero)
    );

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        timer_load = 1'b0;
        timer_dec  = 1'b0;
        case (state_q)
            RUN: begin
                // A redirect wins over a same-cycle fetch transfer.
                if (take) begin
                    state_d    = FLUSH;
                    timer_load = 1'b1;
                    fetch_pc_d = misaligned ? TRAP_VECTOR : ex_pc_next;
                end else if (fetch_valid && fetch_ready) begin
                    fetch_pc_d = fetch_pc_q + PC_STEP;
                end
            end
            FLUSH: begin
                timer_dec = 1'b1;
                if (timer_zero) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RUN;
            fetch_pc_q    <= RESET_PC;
            flush_q       <= 1'b0;
            redirect_q    <= 1'b0;
            exc_q         <= 1'b0;
            exc_pc_q      <= '0;
            taken_count_q <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            flush_q    <= (state_d == FLUSH);
            redirect_q <= take;
            exc_q      <= take && misaligned;
            if (take && misaligned) begin
                exc_pc_q <= ex_pc;
            end
            if (take) begin
                taken_count_q <= taken_count_q + 32'd1;
            end
        end
    end

    assign fetch_pc       = fetch_pc_q;
    assign flush          = flush_q;
    assign redirect       = redirect_q;
    assign exc_misaligned = exc_q;
    assign exc_pc         = exc_pc_q;
    assign taken_count    = taken_count_q;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// tb/tb_pc_redirect_ctrl.sv - scoreboard bench for pc_redirect_ctrl fetch sequencing and redirects
module tb_pc_redirect_ctrl;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [31:0] fetch_pc;
    logic        ex_valid;
    logic        ex_branch;
    logic [31:0] ex_pc;
    logic [31:0] ex_pc_next;
    logic        flush;
    logic        redirect;
    logic        exc_misaligned;
    logic [31:0] exc_pc;
    logic [31:0] taken_count;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_q[$];

    pc_redirect_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .fetch_valid    (fetch_valid),
        .fetch_ready    (fetch_ready),
        .fetch_pc       (fetch_pc),
        .ex_valid       (ex_valid),
        .ex_branch      (ex_branch),
        .ex_pc          (ex_pc),
        .ex_pc_next     (ex_pc_next),
        .flush          (flush),
        .redirect       (redirect),
        .exc_misaligned (exc_misaligned),
        .exc_pc         (exc_pc),
        .taken_count    (taken_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Every fetch handshake seen at the falling edge must match the next queued PC.
    always @(negedge clk) begin
        if (rst_n && fetch_valid && fetch_ready) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_fetch", {32'h0, fetch_pc}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                chk("fetch_pc", {32'h0, fetch_pc}, {32'h0, exp_q.pop_front()});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex(input logic v, input logic b, input logic [31:0] pc, input logic [31:0] nxt);
        ex_valid   = v;
        ex_branch  = b;
        ex_pc      = pc;
        ex_pc_next = nxt;
    endtask

    task automatic run_seq(input int n, input logic [31:0] start);
        logic [31:0] pc;
        pc = start;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(pc);
            pc = pc + 32'd4;
            tick();
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        stall       = 1'b0;
        fetch_ready = 1'b0;
        set_ex(1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        tick();
        chk("rst_fetch_pc", fetch_pc, 32'h0);
        chk("rst_flush", flush, 1'b0);
        chk("rst_redirect", redirect, 1'b0);
        chk("rst_exc", exc_misaligned, 1'b0);
        chk("rst_exc_pc", exc_pc, 32'h0);
        chk("rst_taken", taken_count, 32'h0);
        rst_n       = 1'b1;
        fetch_ready = 1'b1;

        // Sequential fetch from reset.
        run_seq(4, 32'h0);
        chk("seq_flush", flush, 1'b0);
        chk("seq_taken", taken_count, 32'h0);

        // Aligned taken branch; the same-cycle transfer of 0x10 is overridden.
        set_ex(1'b1, 1'b1, 32'h20, 32'h80);
        exp_q.push_back(32'h10);
        tick();
        set_ex(1'b0, 1'b0, 32'h0, 32'h0);
        chk("br_redirect_n1", redirect, 1'b1);
        chk("br_flush_n1", flush, 1'b1);
        chk("br_fv_n1", fetch_valid, 1'b0);
        chk("br_taken", taken_count, 32'd1);
        chk("br_exc_n1", exc_misaligned, 1'b0);
        tick();
        chk("br_redirect_n2", redirect, 1'b0);
        chk("br_flush_n2", flush, 1'b1);
        chk("br_fv_n2", fetch_valid, 1'b0);
        tick();
        chk("br_flush_n3", flush, 1'b0);
        chk("br_fv_n3", fetch_valid, 1'b1);
        run_seq(3, 32'h80);

        // Not-taken branch, and a non-branch with a stray pc_next.
        set_ex(1'b1, 1'b1, 32'h40, 32'h44);
        exp_q.push_back(32'h8C);
        tick();
        set_ex(1'b0, 1'b0, 32'h0, 32'h0);
        chk("nt_redirect", redirect, 1'b0);
        chk("nt_flush", flush, 1'b0);
        chk("nt_taken", taken_count, 32'd1);
        run_seq(2, 32'h90);
        set_ex(1'b1, 1'b0, 32'h50, 32'h300);
        exp_q.push_back(32'h98);
        tick();
        set_ex(1'b0, 1'b0, 32'h0, 32'h0);
        chk("nb_redirect", redirect, 1'b0);
        chk("nb_flush", flush, 1'b0);
        run_seq(1, 32'h9C);

        // Misaligned jalr target traps; a taken branch during the flush is ignored.
        set_ex(1'b1, 1'b1, 32'h30, 32'h102);
        exp_q.push_back(32'hA0);
        tick();
        chk("mis_exc_n1", exc_misaligned, 1'b1);
        chk("mis_exc_pc_n1", exc_pc, 32'h30);
        chk("mis_redirect_n1", redirect, 1'b1);
        chk("mis_taken", taken_count, 32'd2);
        set_ex(1'b1, 1'b1, 32'h60, 32'h200);
        tick();
        chk("mis_exc_n2", exc_misaligned, 1'b0);
        chk("mis_exc_pc_held", exc_pc, 32'h30);
        chk("mis_flush_n2", flush, 1'b1);
        tick();
        set_ex(1'b0, 1'b0, 32'h0, 32'h0);
        chk("ign_taken", taken_count, 32'd2);
        chk("ign_redirect", redirect, 1'b0);
        chk("ign_fv", fetch_valid, 1'b1);
        run_seq(2, 32'h100);

        // Redirect while stalled; stall does not extend the flush.
        stall = 1'b1;
        set_ex(1'b1, 1'b1, 32'h70, 32'h400);
        tick();
        set_ex(1'b0, 1'b0, 32'h0, 32'h0);
        chk("stl_redirect", redirect, 1'b1);
        chk("stl_taken", taken_count, 32'd3);
        tick();
        chk("stl_flush_n2", flush, 1'b1);
        tick();
        chk("stl_flush_n3", flush, 1'b0);
        chk("stl_fv", fetch_valid, 1'b0);
        chk("stl_pc", fetch_pc, 32'h400);
        tick();
        chk("stl_pc_hold", fetch_pc, 32'h400);
        stall = 1'b0;
        run_seq(1, 32'h400);
        fetch_ready = 1'b0;
        tick();
        chk("nrdy_fv", fetch_valid, 1'b1);
        chk("nrdy_pc_hold", fetch_pc, 32'h404);
        fetch_ready = 1'b1;

        // Wrap from the top of the address space.
        set_ex(1'b1, 1'b1, 32'h80, 32'hFFFF_FFFC);
        exp_q.push_back(32'h404);
        tick();
        set_ex(1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        tick();
        run_seq(1, 32'hFFFF_FFFC);
        chk("wrap_pc", fetch_pc, 32'h0);
        run_seq(1, 32'h0);
        chk("wrap_taken", taken_count, 32'd4);

        // Reset in the middle of a flush.
        set_ex(1'b1, 1'b1, 32'h90, 32'h500);
        exp_q.push_back(32'h4);
        tick();
        set_ex(1'b0, 1'b0, 32'h0, 32'h0);
        chk("mr_flush_before", flush, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mr_flush", flush, 1'b0);
        chk("mr_pc", fetch_pc, 32'h0);
        chk("mr_redirect", redirect, 1'b0);
        chk("mr_taken", taken_count, 32'h0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("mr_fv", fetch_valid, 1'b1);
        run_seq(2, 32'h0);

        chk("sb_left", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
